// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared mode, scancode and parser-state definitions
package video_pkg;

    localparam logic [1:0] MODE_COLOR = 2'b00;
    localparam logic [1:0] MODE_GREEN = 2'b01;
    localparam logic [1:0] MODE_AMBER = 2'b10;
    localparam logic [1:0] MODE_BW    = 2'b11;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_SCROLL = 8'h7E;

    typedef enum logic [1:0] {
        PS_IDLE    = 2'b00,
        PS_EXT     = 2'b01,
        PS_EXT_BRK = 2'b10,
        PS_BRK     = 2'b11
    } ps2_state_t;

    // Hotkey cycles colour -> green -> amber -> b/w -> colour.
    function automatic logic [1:0] next_mode(input logic [1:0] mode);
        return mode + 2'd1;
    endfunction

endpackage

// File: rtl/ps2_hotkey_detect.sv
// rtl/ps2_hotkey_detect.sv - set-2 scancode parser emitting one pulse per hotkey press
module ps2_hotkey_detect
    import video_pkg::*;
#(
    parameter logic [7:0] HOTKEY_CODE = SC_SCROLL
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kbd_valid,
    input  logic [7:0] kbd_code,
    output logic       hotkey_make
);

    ps2_state_t state;
    ps2_state_t state_next;
    logic       key_held;
    logic       key_held_next;

    // Parser state and held-key flag; key_held suppresses typematic repeats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= PS_IDLE;
            key_held <= 1'b0;
        end else begin
            state    <= state_next;
            key_held <= key_held_next;
        end
    end

    // Next-state decode; only advances on a received byte.
    always_comb begin
        state_next    = state;
        key_held_next = key_held;
        hotkey_make   = 1'b0;
        if (kbd_valid) begin
            case (state)
                PS_IDLE: begin
                    if (kbd_code == SC_EXT) begin
                        state_next = PS_EXT;
                    end else if (kbd_code == SC_BREAK) begin
                        state_next = PS_BRK;
                    end else if (kbd_code == HOTKEY_CODE) begin
                        // Extended prefixes never reach here, so E0-prefixed
                        // codes sharing the hotkey byte cannot trigger.
                        state_next = PS_IDLE;
                        if (!key_held) begin
                            key_held_next = 1'b1;
                            hotkey_make   = 1'b1;
                        end
                    end else begin
                        state_next = PS_IDLE;
                    end
                end
                PS_EXT: begin
                    if (kbd_code == SC_BREAK) begin
                        state_next = PS_EXT_BRK;
                    end else begin
                        state_next = PS_IDLE;
                    end
                end
                PS_EXT_BRK: begin
                    state_next = PS_IDLE;
                end
                PS_BRK: begin
                    if (kbd_code == HOTKEY_CODE) begin
                        key_held_next = 1'b0;
                    end
                    state_next = PS_IDLE;
                end
                default: begin
                    state_next = PS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/video_mono_mode_ctrl.sv
// rtl/video_mono_mode_ctrl.sv - monochrome mode select with vsync-aligned commit
module video_mono_mode_ctrl
    import video_pkg::*;
#(
    parameter logic [7:0] HOTKEY_CODE      = SC_SCROLL,
    parameter bit         VSYNC_ACTIVE_LOW = 1'b1,
    parameter logic [1:0] RESET_MODE       = MODE_COLOR
) (
    input  logic       clk_vga,
    input  logic       rst,
    input  logic       kbd_valid,
    input  logic [7:0] kbd_code,
    input  logic       io_we,
    input  logic [1:0] io_wdata,
    output logic [1:0] io_rdata,
    input  logic       vga_vsync,
    output logic [1:0] monochrome_switcher,
    output logic       mode_pending
);

    localparam logic VSYNC_INACTIVE = VSYNC_ACTIVE_LOW ? 1'b1 : 1'b0;

    logic       hotkey_make;
    logic       vsync_q;
    logic [1:0] requested;
    logic       req_event;
    logic [1:0] req_value;
    logic       commit;

    ps2_hotkey_detect #(
        .HOTKEY_CODE (HOTKEY_CODE)
    ) u_hotkey (
        .clk         (clk_vga),
        .rst         (rst),
        .kbd_valid   (kbd_valid),
        .kbd_code    (kbd_code),
        .hotkey_make (hotkey_make)
    );

    // Request source arbitration (CPU write beats hotkey) and active vsync edge.
    always_comb begin
        req_event = io_we | hotkey_make;
        req_value = requested;
        if (io_we) begin
            req_value = io_wdata;
        end else if (hotkey_make) begin
            // Based on requested so presses before a commit accumulate.
            req_value = next_mode(requested);
        end
        if (VSYNC_ACTIVE_LOW) begin
            commit = vsync_q & ~vga_vsync;
        end else begin
            commit = ~vsync_q & vga_vsync;
        end
    end

    // Request, pending and commit registers.
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            vsync_q             <= VSYNC_INACTIVE;
            requested           <= RESET_MODE;
            monochrome_switcher <= RESET_MODE;
            mode_pending        <= 1'b0;
        end else begin
            vsync_q <= vga_vsync;
            if (req_event) begin
                requested <= req_value;
            end
            if (commit) begin
                // Commit the value requested before this cycle; a request on
                // the edge cycle waits for the next frame.
                monochrome_switcher <= requested;
                mode_pending        <= req_event && (req_value != requested);
            end else if (req_event) begin
                mode_pending <= (req_value != monochrome_switcher);
            end
        end
    end

    assign io_rdata = monochrome_switcher;

endmodule

// File: tb/tb_video_mono_mode_ctrl.sv
// tb/tb_video_mono_mode_ctrl.sv - directed bench for video_mono_mode_ctrl
module tb_video_mono_mode_ctrl;

    logic       clk_vga = 1'b0;
    logic       rst;
    logic       kbd_valid;
    logic [7:0] kbd_code;
    logic       io_we;
    logic [1:0] io_wdata;
    logic [1:0] io_rdata;
    logic       vga_vsync;
    logic [1:0] monochrome_switcher;
    logic       mode_pending;

    int errors = 0;
    int checks = 0;

    video_mono_mode_ctrl dut (
        .clk_vga             (clk_vga),
        .rst                 (rst),
        .kbd_valid           (kbd_valid),
        .kbd_code            (kbd_code),
        .io_we               (io_we),
        .io_wdata            (io_wdata),
        .io_rdata            (io_rdata),
        .vga_vsync           (vga_vsync),
        .monochrome_switcher (monochrome_switcher),
        .mode_pending        (mode_pending)
    );

    always #5 clk_vga = ~clk_vga;

    task automatic tick();
        @(posedge clk_vga);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        kbd_valid = 1'b0;
        kbd_code  = 8'h00;
        io_we     = 1'b0;
        io_wdata  = 2'b00;
        vga_vsync = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        kbd_valid = 1'b1;
        kbd_code  = b;
        tick();
        kbd_valid = 1'b0;
        kbd_code  = 8'h00;
    endtask

    task automatic vsync_frame();
        vga_vsync = 1'b0;
        tick();
        tick();
        vga_vsync = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (monochrome_switcher !== 2'b00 || mode_pending !== 1'b0 || io_rdata !== 2'b00) begin
            errors++;
            $display("FAIL reset_state: sw=%b pend=%b rd=%b expected sw=00 pend=0 rd=00", monochrome_switcher, mode_pending, io_rdata);
        end
        for (int i = 0; i < 3; i++) begin
            vsync_frame();
            checks++;
            if (monochrome_switcher !== 2'b00 || mode_pending !== 1'b0) begin
                errors++;
                $display("FAIL reset_vsync_%0d: sw=%b pend=%b expected sw=00 pend=0", i, monochrome_switcher, mode_pending);
            end
        end
    endtask

    task automatic test_hotkey_cycle();
        do_reset();
        send_byte(8'h7E);
        checks++;
        if (mode_pending !== 1'b1 || monochrome_switcher !== 2'b00) begin
            errors++;
            $display("FAIL hk_pending: pend=%b sw=%b expected pend=1 sw=00", mode_pending, monochrome_switcher);
        end
        send_byte(8'hF0);
        send_byte(8'h7E);
        vga_vsync = 1'b0;
        checks++;
        if (monochrome_switcher !== 2'b00) begin
            errors++;
            $display("FAIL hk_before_edge: sw=%b expected 00", monochrome_switcher);
        end
        tick();
        checks++;
        if (monochrome_switcher !== 2'b01 || mode_pending !== 1'b0 || io_rdata !== 2'b01) begin
            errors++;
            $display("FAIL hk_commit: sw=%b pend=%b rd=%b expected sw=01 pend=0 rd=01", monochrome_switcher, mode_pending, io_rdata);
        end
        vga_vsync = 1'b1;
        tick();
    endtask

    task automatic test_typematic();
        do_reset();
        send_byte(8'h7E);
        send_byte(8'h7E);
        send_byte(8'h7E);
        vsync_frame();
        checks++;
        if (monochrome_switcher !== 2'b01 || mode_pending !== 1'b0) begin
            errors++;
            $display("FAIL typematic_first: sw=%b pend=%b expected sw=01 pend=0", monochrome_switcher, mode_pending);
        end
        send_byte(8'hF0);
        send_byte(8'h7E);
        send_byte(8'h7E);
        vsync_frame();
        checks++;
        if (monochrome_switcher !== 2'b10) begin
            errors++;
            $display("FAIL typematic_second: sw=%b expected 10", monochrome_switcher);
        end
    endtask

    task automatic test_extended();
        do_reset();
        send_byte(8'hE0);
        send_byte(8'h7E);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h7E);
        checks++;
        if (mode_pending !== 1'b0) begin
            errors++;
            $display("FAIL ext_pending: pend=%b expected 0", mode_pending);
        end
        vsync_frame();
        vsync_frame();
        checks++;
        if (monochrome_switcher !== 2'b00 || mode_pending !== 1'b0) begin
            errors++;
            $display("FAIL ext_frames: sw=%b pend=%b expected sw=00 pend=0", monochrome_switcher, mode_pending);
        end
        // Parser must be back in IDLE: a plain make now works.
        send_byte(8'h7E);
        checks++;
        if (mode_pending !== 1'b1) begin
            errors++;
            $display("FAIL ext_then_make: pend=%b expected 1", mode_pending);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        kbd_valid = 1'b1;
        kbd_code  = 8'h7E;
        io_we     = 1'b1;
        io_wdata  = 2'b11;
        tick();
        kbd_valid = 1'b0;
        io_we     = 1'b0;
        checks++;
        if (mode_pending !== 1'b1) begin
            errors++;
            $display("FAIL sim_pending: pend=%b expected 1", mode_pending);
        end
        vsync_frame();
        checks++;
        if (monochrome_switcher !== 2'b11 || io_rdata !== 2'b11) begin
            errors++;
            $display("FAIL sim_commit: sw=%b rd=%b expected 11", monochrome_switcher, io_rdata);
        end
        send_byte(8'h7E);
        checks++;
        if (mode_pending !== 1'b0) begin
            errors++;
            $display("FAIL sim_repeat_pending: pend=%b expected 0", mode_pending);
        end
        vsync_frame();
        checks++;
        if (monochrome_switcher !== 2'b11) begin
            errors++;
            $display("FAIL sim_repeat_mode: sw=%b expected 11", monochrome_switcher);
        end
        // Release then press: 11 wraps to 00.
        send_byte(8'hF0);
        send_byte(8'h7E);
        send_byte(8'h7E);
        checks++;
        if (mode_pending !== 1'b1) begin
            errors++;
            $display("FAIL wrap_pending: pend=%b expected 1", mode_pending);
        end
        vsync_frame();
        checks++;
        if (monochrome_switcher !== 2'b00) begin
            errors++;
            $display("FAIL wrap_commit: sw=%b expected 00", monochrome_switcher);
        end
    endtask

    task automatic test_accumulate();
        do_reset();
        send_byte(8'h7E);
        send_byte(8'hF0);
        send_byte(8'h7E);
        send_byte(8'h7E);
        vsync_frame();
        checks++;
        if (monochrome_switcher !== 2'b10) begin
            errors++;
            $display("FAIL accumulate: sw=%b expected 10", monochrome_switcher);
        end
        // Request equal to committed mode clears pending.
        io_we    = 1'b1;
        io_wdata = 2'b01;
        tick();
        io_we    = 1'b0;
        io_wdata = 2'b10;
        io_we    = 1'b1;
        tick();
        io_we    = 1'b0;
        checks++;
        if (mode_pending !== 1'b0) begin
            errors++;
            $display("FAIL equal_clears: pend=%b expected 0", mode_pending);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        vga_vsync = 1'b0;
        io_we     = 1'b1;
        io_wdata  = 2'b01;
        tick();
        io_we = 1'b0;
        checks++;
        if (monochrome_switcher !== 2'b00 || mode_pending !== 1'b1) begin
            errors++;
            $display("FAIL edge_req_first: sw=%b pend=%b expected sw=00 pend=1", monochrome_switcher, mode_pending);
        end
        tick();
        vga_vsync = 1'b1;
        tick();
        tick();
        checks++;
        if (monochrome_switcher !== 2'b00 || mode_pending !== 1'b1) begin
            errors++;
            $display("FAIL edge_rise_nocommit: sw=%b pend=%b expected sw=00 pend=1", monochrome_switcher, mode_pending);
        end
        vga_vsync = 1'b0;
        tick();
        checks++;
        if (monochrome_switcher !== 2'b01 || mode_pending !== 1'b0) begin
            errors++;
            $display("FAIL edge_req_next: sw=%b pend=%b expected sw=01 pend=0", monochrome_switcher, mode_pending);
        end
        vga_vsync = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_byte(8'h7E);
        send_byte(8'hE0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (monochrome_switcher !== 2'b00 || mode_pending !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: sw=%b pend=%b expected sw=00 pend=0", monochrome_switcher, mode_pending);
        end
        tick();
        rst = 1'b0;
        tick();
        send_byte(8'h7E);
        checks++;
        if (mode_pending !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_make: pend=%b expected 1", mode_pending);
        end
        vsync_frame();
        checks++;
        if (monochrome_switcher !== 2'b01) begin
            errors++;
            $display("FAIL reset_mid_commit: sw=%b expected 01", monochrome_switcher);
        end
    endtask

    initial begin
        test_reset();
        test_hotkey_cycle();
        test_typematic();
        test_extended();
        test_simultaneous();
        test_accumulate();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/video_mono_mode_ctrl.md
Name: video_mono_mode_ctrl

Overview:
- Produces the 2-bit monochrome mode select consumed by the VGA colour/monochrome output stage: 00 colour, 01 green, 10 amber, 11 black-and-white.
- Mode changes come from two sources:
  - a Scroll Lock hotkey decoded from the PS/2 keyboard scancode stream (set 2);
  - a CPU I/O port write.
- Requested changes are held pending and committed only at the next vertical sync edge, so no frame is ever displayed in a mixed palette.

Parameters:
- HOTKEY_CODE, 8'h7E, set-2 make code that cycles the mode (Scroll Lock).
- VSYNC_ACTIVE_LOW, 1, 1: commit on vsync falling edge; 0: commit on rising edge.
- RESET_MODE, 2'b00, mode loaded on reset.

Ports:
- clk_vga  in  1  video clock, all logic on rising edge
- rst  in  1  asynchronous active-high reset
- kbd_valid  in  1  one-cycle strobe: kbd_code holds a received scancode byte
- kbd_code  in  8  scancode byte from the PS/2 receiver
- io_we  in  1  one-cycle CPU write strobe to the mode port
- io_wdata  in  2  requested mode on an io_we cycle
- io_rdata  out  2  committed mode (combinational copy of monochrome_switcher)
- vga_vsync  in  1  vsync as driven to the VGA pin, synchronous to clk_vga
- monochrome_switcher  out  2  committed mode to the colour stage
- mode_pending  out  1  high while a requested mode awaits commit

Behaviour:
- Reset (asynchronous, any time, including mid-sequence):
  - monochrome_switcher = RESET_MODE; requested = RESET_MODE; mode_pending = 0.
  - Parser state = IDLE; key_held = 0; vsync_q = inactive level.
- Scancode parser FSM, advances only on kbd_valid:
  - IDLE: E0 -> EXT; F0 -> BRK; HOTKEY_CODE -> hotkey make event; any other byte -> stay IDLE.
  - EXT: F0 -> EXT_BRK; any other byte -> IDLE, no event. Extended codes never trigger.
  - EXT_BRK: any byte -> IDLE, no event.
  - BRK: HOTKEY_CODE -> key_held = 0, then IDLE; any other byte -> IDLE.
- Hotkey make event:
  - If key_held = 0: set key_held = 1 and request mode = requested + 1 (2-bit wrap, 11 -> 00).
  - If key_held = 1 (typematic repeat): no action.
- CPU write: on io_we, requested = io_wdata. No held-key check applies.
- Simultaneous io_we and hotkey event in the same cycle:
  - CPU write wins; requested = io_wdata.
  - key_held is still set, so the repeat is suppressed.
- mode_pending:
  - Set the cycle after any request where requested != monochrome_switcher.
  - A request equal to the committed mode clears mode_pending.
- Requests accumulate: two hotkey presses before a commit advance by 2, because increments are based on requested, not committed.
- Commit:
  - vsync_q registers vga_vsync each cycle.
  - Active edge (falling when VSYNC_ACTIVE_LOW = 1) is detected the cycle vga_vsync differs from vsync_q toward the active level.
  - On that cycle monochrome_switcher <= requested and mode_pending <= 0. Latency is one clk_vga cycle after the pin edge.
- Request arriving on the same cycle as the commit edge: the commit uses the old requested value; the new request goes pending for the next frame.
- If no vsync ever toggles, the mode stays pending indefinitely.

Decomposition:
- Shared package video_pkg holds:
  - mode constants MODE_COLOR = 2'b00, MODE_GREEN = 2'b01, MODE_AMBER = 2'b10, MODE_BW = 2'b11;
  - scancode constants SC_EXT = 8'hE0, SC_BREAK = 8'hF0, SC_SCROLL = 8'h7E;
  - parser state encoding.
- One natural sub-module, ps2_hotkey_detect: the scancode FSM plus key_held, emitting a single-cycle hotkey_make pulse.
- The request/pending/commit logic stays in the top module.

Test Plan:
- Reset, then vsync toggling -> monochrome_switcher = 00 and mode_pending = 0 throughout.
- Bytes 7E, F0, 7E, then one vsync falling edge -> mode_pending rises after the first 7E; monochrome_switcher goes 00 -> 01 one cycle after the edge; mode_pending = 0.
- Bytes 7E, 7E, 7E (typematic repeat), then vsync -> mode 01 only. Then F0 7E, 7E, vsync -> mode 10.
- Bytes E0 7E and E0 F0 7E -> no mode change and mode_pending stays 0 across two frames.
- io_we with io_wdata = 11 in the same cycle as a 7E make, then vsync -> mode 11. A following 7E without a break -> ignored.
- Request 01 applied in the exact cycle of a vsync edge -> that frame commits the old value; commit to 01 at the next edge. Also: assert rst mid-sequence after E0 -> the next 7E acts as a normal make.
